databus_arbiter: RTL and testbench
==================================

# databus_arbiter

Arbitrates the single shared data bus to the storage hierarchy between the pipeline's instruction-fetch port (IF) and load/store port (MEM). It runs one transaction at a time over a level req/ack bus. It produces `Databus_busy` and `Databus_done`, which the pipeline stall controller uses to freeze all six stages while a bus access is outstanding.

## Interface
Parameters:
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width; `DATA_W/8` byte selects.
- `STARVE_LIMIT`, 4, consecutive contested MEM grants after which IF wins one contested grant (1..15).
- `TIMEOUT_CYCLES`, 1024, XFER cycles before abort. Used only with `DATABUS_TIMEOUT_EN`; must be at least 2.

Ports:
- `clk` in 1: the single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `if_req` in 1: fetch request, level, held until `if_ack`.
- `if_addr` in ADDR_W: fetch address.
- `if_rdata` out DATA_W: fetch data, valid while `if_ack`.
- `if_ack` out 1: one-cycle fetch completion.
- `mem_req` in 1: load/store request, level, held until `mem_ack`.
- `mem_we` in 1: 1 selects a store.
- `mem_addr` in ADDR_W, `mem_wdata` in DATA_W, `mem_sel` in DATA_W/8: access address, write data, byte enables.
- `mem_rdata` out DATA_W: load data, valid while `mem_ack`.
- `mem_ack` out 1: one-cycle load/store completion.
- `bus_req` out 1: request to storage, registered, held until `bus_ack`.
- `bus_we` out 1, `bus_addr` out ADDR_W, `bus_wdata` out DATA_W, `bus_sel` out DATA_W/8: registered at grant and stable through XFER. IF grants drive `we=0` and all-ones `sel`.
- `bus_rdata` in DATA_W: storage read data, sampled with `bus_ack`.
- `bus_ack` in 1: storage completion pulse.
- `Databus_busy` out 1: a transaction is in flight.
- `Databus_done` out 1: the pipeline may advance.
- `timeout_err` out 1: sticky abort flag; tied 0 without `DATABUS_TIMEOUT_EN`.

## Operation
- States: IDLE, XFER, RESP.
- IDLE → XFER when `if_req | mem_req`:
  - The winner is latched into `grant`.
  - Bus outputs are registered from the winner.
  - `bus_req` becomes 1.
- Priority: MEM wins a contested grant unless `streak == STARVE_LIMIT`, in which case IF wins.
  - `streak` (4 bits) increments on each MEM grant made while `if_req` = 1.
  - `streak` clears on any IF grant.
  - `streak` saturates at `STARVE_LIMIT`.
- XFER → RESP on `bus_ack`:
  - `bus_req` drops.
  - `bus_rdata` is captured into the granted port's rdata register.
  - That port's ack is 1 for the RESP cycle only.
- RESP → IDLE unconditionally. Back-to-back requests therefore cost one IDLE cycle between transactions.
- `Databus_busy` = (state != IDLE).
- `Databus_done` is high in exactly two cases:
  - IDLE and no request is pending.
  - RESP and the non-granted port is not requesting.

  In every other cycle it is 0, so the pipeline stays frozen until every asserted request has been served.
- rdata registers hold their last value between acks. Stores return rdata unchanged from its previous value.
- `bus_ack` outside XFER is ignored.
- A requester dropping `req` before its ack is a protocol violation. The transaction still completes and the ack is still issued.

## Timing
- Request seen in IDLE at cycle 0 → `bus_req` = 1 in cycle 1.
- `bus_ack` in cycle k → port ack and rdata in cycle k+1 → IDLE in cycle k+2.
- Minimum latency, request to ack, is 3 cycles (`bus_ack` in cycle 1).
- Requesters deassert `req` at the edge ending their ack cycle.
- Reset, whether idle or mid-transaction, takes effect at the next edge:
  - state = IDLE; `bus_req`, `if_ack`, `mem_ack`, `timeout_err` = 0.
  - rdata registers, bus outputs, `streak`, timeout counter = 0.
  - After reset, `Databus_busy` = 0 and `Databus_done` = !(if_req | mem_req).
  - A reset mid-XFER abandons the access with no ack. The storage side treats a dropped `bus_req` as a cancel.

## Configuration
- `DATABUS_TIMEOUT_EN` defined:
  - A counter clears on XFER entry and increments each XFER cycle without `bus_ack`.
  - When it reaches `TIMEOUT_CYCLES-1` without ack, the block drops `bus_req` and moves to RESP.
  - In that RESP it delivers rdata = 0 and the normal ack, and sets `timeout_err` until reset.
  - A `bus_ack` arriving on the final count cycle completes normally with no error.
- `DATABUS_TIMEOUT_EN` undefined: no counter, XFER waits indefinitely, and `timeout_err` = 0.

## Test plan
- Single fetch: `if_req`, `if_addr`=0x100; `bus_ack` 2 cycles after `bus_req` with `bus_rdata`=0xDEADBEEF → `if_ack` one cycle with `if_rdata`=0xDEADBEEF; `Databus_done` low from request to the RESP cycle.
- Contention: `if_req` and `mem_req` (store, `sel`=4'b0011) asserted in the same cycle → MEM served first, `Databus_done`=0 in MEM's RESP, IF served next, `Databus_done`=1 in IF's RESP.
- Starvation: `mem_req` held continuously with `if_req` pending, `STARVE_LIMIT`=4 → 4 MEM grants, then 1 IF grant, then MEM again.
- Reset mid-XFER: `rst` for 1 cycle while `bus_req`=1 → next cycle `bus_req`=0, no ack, `Databus_busy`=0, `streak`=0.
- Timeout (macro on, `TIMEOUT_CYCLES`=8): no `bus_ack` → `bus_req` drops after 8 XFER cycles, `mem_ack` with `mem_rdata`=0, `timeout_err`=1 until reset. Macro off → `bus_req` is still held after 100 cycles.

Source files
------------

// File: rtl/databus_arbiter.sv
// databus_arbiter: arbitrates the shared storage data bus between the
// instruction-fetch port (IF) and the load/store port (MEM). One transaction
// at a time over a level req/ack bus. MEM wins contested grants unless IF has
// lost STARVE_LIMIT contested grants in a row.
// Optional feature macro: DATABUS_TIMEOUT_EN. When defined, a stuck transfer
// is aborted after TIMEOUT_CYCLES cycles and timeout_err is set until reset.
module databus_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int STARVE_LIMIT   = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                rst,
    // instruction-fetch port
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_ack,
    // load/store port
    input  logic                mem_req,
    input  logic                mem_we,
    input  logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W/8-1:0] mem_sel,
    output logic [DATA_W-1:0]   mem_rdata,
    output logic                mem_ack,
    // storage side
    output logic                bus_req,
    output logic                bus_we,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W-1:0]   bus_wdata,
    output logic [DATA_W/8-1:0] bus_sel,
    input  logic [DATA_W-1:0]   bus_rdata,
    input  logic                bus_ack,
    // pipeline stall interface
    output logic                Databus_busy,
    output logic                Databus_done,
    output logic                timeout_err
);

    typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;
    typedef enum logic {GNT_IF, GNT_MEM} grant_t;

    // Reject configurations the streak counter or timeout counter cannot honour.
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("databus_arbiter: STARVE_LIMIT must be 1..15 and TIMEOUT_CYCLES at least 2");
    end

    state_t     state;
    state_t     state_next;
    grant_t     grant;
    logic [3:0] streak;
    logic       mem_wins;   // MEM takes the grant if one starts this cycle
    logic       start;      // IDLE -> XFER this cycle
    logic       finish;     // XFER -> RESP this cycle
    logic       timed_out;  // XFER abandoned this cycle for lack of bus_ack

`ifdef DATABUS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] tmo_cnt;
    logic             err_q;

    // A bus_ack on the last count cycle still wins over the abort.
    assign timed_out   = (state == XFER) && !bus_ack && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign timeout_err = err_q;

    // Count unacknowledged XFER cycles; latch the sticky error on abort.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            if (start) begin
                tmo_cnt <= '0;
            end else if (state == XFER && !bus_ack) begin
                tmo_cnt <= tmo_cnt + CNT_W'(1);
            end
            if (timed_out) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    assign timed_out   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // Next-state logic, grant decision and the stall-controller outputs.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
        state_next   = state;
        start        = 1'b0;
        finish       = 1'b0;
        Databus_done = 1'b0;
        mem_wins     = mem_req && !(if_req && streak == 4'(STARVE_LIMIT));
        Databus_busy = (state != IDLE);

        case (state)
            IDLE: begin
                if (if_req || mem_req) begin
                    state_next = XFER;
                    start      = 1'b1;
                end else begin
                    Databus_done = 1'b1;
                end
            end
            XFER: begin
                if (bus_ack || timed_out) begin
                    state_next = RESP;
                    finish     = 1'b1;
                end
            end
            RESP: begin
                state_next   = IDLE;
                Databus_done = (grant == GNT_IF) ? !mem_req : !if_req;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Grant, starvation streak, registered bus outputs, acks and read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the read-data holding registers are ordinary flops with a defined reset value, so they are cleared here like the rest.
            grant     <= GNT_IF;
            streak    <= '0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_sel   <= '0;
            if_ack    <= 1'b0;
            mem_ack   <= 1'b0;
            if_rdata  <= '0;
            mem_rdata <= '0;
        end else begin
            if_ack  <= 1'b0;
            mem_ack <= 1'b0;

            if (start) begin
                bus_req <= 1'b1;
                if (mem_wins) begin
                    grant     <= GNT_MEM;
                    bus_we    <= mem_we;
                    bus_addr  <= mem_addr;
                    bus_wdata <= mem_wdata;
                    bus_sel   <= mem_sel;
                    // Only a grant that made IF wait counts toward starvation.
                    if (if_req && streak != 4'(STARVE_LIMIT)) begin
                        streak <= streak + 4'd1;
                    end
                end else begin
                    grant     <= GNT_IF;
                    bus_we    <= 1'b0;
                    bus_addr  <= if_addr;
                    bus_wdata <= '0;
                    bus_sel   <= '1;
                    streak    <= '0;
                end
            end

            if (finish) begin
                bus_req <= 1'b0;
                if (grant == GNT_IF) begin
                    if_ack   <= 1'b1;
                    if_rdata <= timed_out ? '0 : bus_rdata;
                end else begin
                    mem_ack <= 1'b1;
                    // Stores leave the load data register untouched.
                    if (!bus_we) begin
                        mem_rdata <= timed_out ? '0 : bus_rdata;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_databus_arbiter.sv
// tb_databus_arbiter: directed self-checking bench for databus_arbiter.
// Inputs change 1 time unit after the rising edge; outputs are checked on the
// falling edge. Covers reset, a single fetch, IF/MEM contention with a store,
// starvation relief, timeout (or indefinite hold without DATABUS_TIMEOUT_EN)
// and a reset that lands mid-transfer.
module tb_databus_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ack;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [3:0]        mem_sel;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;
    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic [3:0]        bus_sel;
    logic [DATA_W-1:0] bus_rdata;
    logic              bus_ack;
    logic              Databus_busy;
    logic              Databus_done;
    logic              timeout_err;

    int total = 0;
    int bad   = 0;

    databus_arbiter #(
        .ADDR_W        (ADDR_W),
        .DATA_W        (DATA_W),
        .STARVE_LIMIT  (4),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_rdata    (if_rdata),
        .if_ack      (if_ack),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_sel     (mem_sel),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .bus_req     (bus_req),
        .bus_we      (bus_we),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_sel     (bus_sel),
        .bus_rdata   (bus_rdata),
        .bus_ack     (bus_ack),
        .Databus_busy(Databus_busy),
        .Databus_done(Databus_done),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge (input drive point).
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Move to the falling edge of the current cycle (check point).
    task automatic neg();
        @(negedge clk);
    endtask

    logic exp_if;

    initial begin
        rst       = 1'b1;
        if_req    = 1'b0;
        if_addr   = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_sel   = '0;
        bus_rdata = '0;
        bus_ack   = 1'b0;
        cyc();
        cyc();

        // ---------------- reset state
        neg();
        check("rst_busy", Databus_busy, 0);
        check("rst_done", Databus_done, 1);
        check("rst_bus_req", bus_req, 0);
        check("rst_if_ack", if_ack, 0);
        check("rst_mem_ack", mem_ack, 0);
        check("rst_if_rdata", if_rdata, 0);
        check("rst_tmo_err", timeout_err, 0);
        cyc();
        rst = 1'b0;

        // ---------------- single fetch, bus_ack two cycles after bus_req
        cyc();
        if_req  = 1'b1;
        if_addr = 32'h100;
        neg();
        check("f_idle_done", Databus_done, 0);
        check("f_idle_busy", Databus_busy, 0);
        cyc();                                // XFER cycle 1
        neg();
        check("f_bus_req", bus_req, 1);
        check("f_bus_addr", bus_addr, 32'h100);
        check("f_bus_we", bus_we, 0);
        check("f_bus_sel", bus_sel, 4'hF);
        check("f_busy", Databus_busy, 1);
        check("f_done_x1", Databus_done, 0);
        cyc();                                // XFER cycle 2
        neg();
        check("f_no_early_ack", if_ack, 0);
        cyc();                                // XFER cycle 3: storage answers
        bus_ack   = 1'b1;
        bus_rdata = 32'hDEADBEEF;
        neg();
        check("f_done_x3", Databus_done, 0);
        cyc();                                // RESP
        bus_ack = 1'b0;
        neg();
        check("f_if_ack", if_ack, 1);
        check("f_if_rdata", if_rdata, 32'hDEADBEEF);
        check("f_resp_bus_req", bus_req, 0);
        check("f_resp_done", Databus_done, 1);
        check("f_resp_busy", Databus_busy, 1);
        cyc();                                // back in IDLE
        if_req = 1'b0;
        neg();
        check("f_ack_one_cycle", if_ack, 0);
        check("f_rdata_hold", if_rdata, 32'hDEADBEEF);
        check("f_idle_busy2", Databus_busy, 0);
        check("f_idle_done2", Databus_done, 1);

        // ---------------- contention: MEM store first, then IF fetch
        cyc();
        if_req    = 1'b1;
        if_addr   = 32'h104;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = 32'h200;
        mem_wdata = 32'hCAFEF00D;
        mem_sel   = 4'b0011;
        neg();
        check("c_idle_done", Databus_done, 0);
        cyc();                                // XFER (MEM)
        bus_ack   = 1'b1;
        bus_rdata = 32'h11111111;
        neg();
        check("c_m_we", bus_we, 1);
        check("c_m_addr", bus_addr, 32'h200);
        check("c_m_wdata", bus_wdata, 32'hCAFEF00D);
        check("c_m_sel", bus_sel, 4'b0011);
        cyc();                                // RESP (MEM)
        bus_ack = 1'b0;
        neg();
        check("c_m_ack", mem_ack, 1);
        check("c_m_if_ack", if_ack, 0);
        check("c_m_done", Databus_done, 0);
        check("c_store_rdata", mem_rdata, 0);
        cyc();                                // IDLE, IF still waiting
        mem_req = 1'b0;
        neg();
        check("c_gap_done", Databus_done, 0);
        check("c_gap_busy", Databus_busy, 0);
        cyc();                                // XFER (IF)
        bus_ack   = 1'b1;
        bus_rdata = 32'h12345678;
        neg();
        check("c_i_we", bus_we, 0);
        check("c_i_addr", bus_addr, 32'h104);
        check("c_i_sel", bus_sel, 4'hF);
        cyc();                                // RESP (IF)
        bus_ack = 1'b0;
        neg();
        check("c_i_ack", if_ack, 1);
        check("c_i_rdata", if_rdata, 32'h12345678);
        check("c_i_done", Databus_done, 1);
        cyc();
        if_req = 1'b0;

        // ---------------- starvation: MEM held, IF pending, bus_ack held high
        // (bus_ack outside XFER must be ignored, giving 3-cycle transactions)
        cyc();
        if_req   = 1'b1;
        if_addr  = 32'h600;
        mem_req  = 1'b1;
        mem_we   = 1'b0;
        mem_addr = 32'h700;
        bus_ack  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            exp_if = (i == 4);
            neg();
            check($sformatf("s%0d_idle_done", i), Databus_done, 0);
            check($sformatf("s%0d_idle_busy", i), Databus_busy, 0);
            cyc();                            // XFER
            bus_rdata = 32'h1000 + i;
            neg();
            check($sformatf("s%0d_addr", i), bus_addr, exp_if ? 32'h600 : 32'h700);
            cyc();                            // RESP
            neg();
            check($sformatf("s%0d_if_ack", i), if_ack, exp_if);
            check($sformatf("s%0d_mem_ack", i), mem_ack, !exp_if);
            check($sformatf("s%0d_done", i), Databus_done, exp_if ? !mem_req : !if_req);
            if (exp_if) check($sformatf("s%0d_rdata", i), if_rdata, 32'h1000 + i);
            else        check($sformatf("s%0d_rdata", i), mem_rdata, 32'h1000 + i);
            cyc();                            // next IDLE
            if (exp_if) if_req = 1'b0;
        end
        mem_req = 1'b0;
        bus_ack = 1'b0;
        neg();
        check("s_end_busy", Databus_busy, 0);

`ifdef DATABUS_TIMEOUT_EN
        // ---------------- timeout: load never acknowledged
        cyc();
        mem_req  = 1'b1;
        mem_we   = 1'b0;
        mem_addr = 32'h500;
        for (int i = 0; i < 8; i++) begin
            cyc();                            // XFER cycles 1..8
            neg();
            check($sformatf("t_hold%0d", i), bus_req, 1);
        end
        cyc();                                // RESP after abort
        neg();
        check("t_bus_req_drop", bus_req, 0);
        check("t_mem_ack", mem_ack, 1);
        check("t_mem_rdata", mem_rdata, 0);
        check("t_err", timeout_err, 1);
        cyc();
        mem_req = 1'b0;
        neg();
        check("t_err_sticky", timeout_err, 1);
        // start a contested transfer for the reset test
        cyc();
        if_req  = 1'b1;
        mem_req = 1'b1;
        cyc();                                // XFER (MEM, streak 1)
`else
        // ---------------- no timeout: contested load held 100 cycles without ack
        cyc();
        if_req   = 1'b1;
        mem_req  = 1'b1;
        mem_we   = 1'b0;
        mem_addr = 32'h500;
        cyc();                                // XFER (MEM, streak 1)
        repeat (99) cyc();
        neg();
        check("h_bus_req_100", bus_req, 1);
        check("h_busy_100", Databus_busy, 1);
        check("h_no_ack", mem_ack, 0);
        check("h_err", timeout_err, 0);
        cyc();
`endif

        // ---------------- reset while bus_req is high
        rst = 1'b1;
        neg();
        check("r_pre_bus_req", bus_req, 1);
        check("r_pre_streak", dut.streak, 1);
        cyc();
        rst     = 1'b0;
        if_req  = 1'b0;
        mem_req = 1'b0;
        neg();
        check("r_bus_req", bus_req, 0);
        check("r_busy", Databus_busy, 0);
        check("r_done", Databus_done, 1);
        check("r_mem_ack", mem_ack, 0);
        check("r_if_ack", if_ack, 0);
        check("r_streak", dut.streak, 0);
        check("r_mem_rdata", mem_rdata, 0);
        check("r_if_rdata", if_rdata, 0);
        check("r_err", timeout_err, 0);
        cyc();
        neg();
        check("r_no_late_ack", mem_ack, 0);
        check("r_idle", Databus_busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
